// File: rtl/uiicmp_pkg_rx_pkg.sv
// ==========================================================================
// uiicmp_pkg_rx_pkg : shared encodings and checksum helpers for ICMP echo rx
// Revision: 1.0
// ==========================================================================
`default_nettype none

package uiicmp_pkg_rx_pkg;

   localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'h08;
   localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'h00;
   localparam logic [7:0] ICMP_CODE_ECHO       = 8'h00;
   localparam int         ICMP_HDR_LEN         = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DROP    = 3'd4,
      ST_REQ     = 3'd5,
      ST_DRAIN   = 3'd6
   } echo_rx_state_t;

   function automatic logic [15:0] cksum_fold(input logic [31:0] s);
      logic [31:0] t;
      t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
      return t[15:0];
   endfunction

   // Changing the type byte 8 -> 0 raises the one's-complement checksum by 0x0800.
   function automatic logic [15:0] reply_cksum(input logic [15:0] req);
      logic [16:0] t;
      t = {1'b0, req} + 17'h00800;
      return t[15:0] + {15'h0, t[16]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/uiicmp_echo_fifo.sv
// ==========================================================================
// uiicmp_echo_fifo : show-ahead byte FIFO with speculative write/commit/rewind
// Revision: 1.0
// ==========================================================================
`default_nettype none

module uiicmp_echo_fifo #(
   parameter int DEPTH = 512
) (
   input  logic       I_clk,
   input  logic       I_reset,
   input  logic       I_wr_en,
   input  logic [7:0] I_wr_data,
   input  logic       I_commit,
   input  logic       I_rewind,
   input  logic       I_rd_en,
   output logic [7:0] O_rd_data,
   output logic       O_empty
);

   localparam int c_AW = $clog2(DEPTH);

   // One extra pointer bit separates a full buffer from an empty one.
   logic [c_AW:0] r_wr_spec;
   logic [c_AW:0] r_wr_commit;
   logic [c_AW:0] r_rd_ptr;
   logic [7:0]    r_mem [DEPTH];
   logic          w_empty;

   assign w_empty   = (r_rd_ptr == r_wr_commit);
   assign O_empty   = w_empty;
   assign O_rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge I_clk) begin
      if (I_wr_en) begin
         r_mem[r_wr_spec[c_AW-1:0]] <= I_wr_data;
      end
   end

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         r_wr_spec   <= '0;
         r_wr_commit <= '0;
         r_rd_ptr    <= '0;
      end else begin
         if (I_rewind) begin
            r_wr_spec <= r_wr_commit;
         end else if (I_wr_en) begin
            r_wr_spec <= r_wr_spec + 1'b1;
         end
         if (I_commit) begin
            r_wr_commit <= r_wr_spec;
         end
         if (I_rd_en && !w_empty) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uiicmp_pkg_rx.sv
// ==========================================================================
// uiicmp_pkg_rx : ICMP receive stage, validates echo requests for the replier
// Revision: 1.0
// ==========================================================================
`default_nettype none

module uiicmp_pkg_rx
   import uiicmp_pkg_rx_pkg::*;
#(
   parameter int ECHO_DEPTH = 512
) (
   input  logic        I_clk,
   input  logic        I_reset,
   input  logic        I_icmp_valid,
   input  logic [7:0]  I_icmp_data,
   input  logic [31:0] I_icmp_src_ip_addr,
   output logic        O_icmp_req_en,
   output logic [15:0] O_icmp_req_id,
   output logic [15:0] O_icmp_req_sq_num,
   output logic [15:0] O_icmp_req_checksum,
   output logic [31:0] O_icmp_req_ip_addr,
   output logic [9:0]  O_icmp_ping_echo_data_len,
   output logic [7:0]  O_icmp_ping_echo_data,
   input  logic        I_icmp_ping_echo_ren,
   output logic        O_icmp_rx_drop
);

   localparam logic [9:0] c_DEPTH = 10'(ECHO_DEPTH);

   echo_rx_state_t r_state;
   logic [7:0]  r_type;
   logic [7:0]  r_code;
   logic [7:0]  r_hi;
   logic        r_odd;
   logic [2:0]  r_idx;
   logic [15:0] r_cksum;
   logic [15:0] r_id;
   logic [15:0] r_seq;
   logic [31:0] r_src_ip;
   logic [31:0] r_acc;
   logic [9:0]  r_pay_cnt;
   logic        r_too_big;
   logic [9:0]  r_drain_cnt;
   logic        r_skip;

   logic        r_req_en;
   logic        r_drop;
   logic [15:0] r_o_id;
   logic [15:0] r_o_seq;
   logic [15:0] r_o_cksum;
   logic [31:0] r_o_ip;
   logic [9:0]  r_o_len;

   logic        w_wr_en;
   logic        w_empty;
   logic        w_pop;
   logic        w_good;
   logic [31:0] w_acc_next;
   logic [31:0] w_sum;

   assign w_wr_en    = (r_state == ST_PAYLOAD) && I_icmp_valid && (r_pay_cnt != c_DEPTH);
   assign w_pop      = I_icmp_ping_echo_ren && !w_empty;
   assign w_acc_next = r_odd ? (r_acc + {16'h0, r_hi, I_icmp_data}) : r_acc;
   assign w_sum      = r_acc + (r_odd ? {16'h0, r_hi, 8'h00} : 32'h0);
   assign w_good     = (r_type == ICMP_TYPE_ECHO_REQ) && (r_code == ICMP_CODE_ECHO) &&
                       !r_too_big && (cksum_fold(w_sum) == 16'hFFFF);

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         r_state     <= ST_IDLE;
         r_type      <= '0;
         r_code      <= '0;
         r_hi        <= '0;
         r_odd       <= 1'b0;
         r_idx       <= '0;
         r_cksum     <= '0;
         r_id        <= '0;
         r_seq       <= '0;
         r_src_ip    <= '0;
         r_acc       <= '0;
         r_pay_cnt   <= '0;
         r_too_big   <= 1'b0;
         r_drain_cnt <= '0;
         r_skip      <= 1'b0;
         r_req_en    <= 1'b0;
         r_drop      <= 1'b0;
         r_o_id      <= '0;
         r_o_seq     <= '0;
         r_o_cksum   <= '0;
         r_o_ip      <= '0;
         r_o_len     <= '0;
      end else begin
         r_req_en <= 1'b0;
         r_drop   <= 1'b0;
         // A packet that starts while the parser is busy is consumed and dropped at its end.
         if (I_icmp_valid && (r_skip || !(r_state inside {ST_IDLE, ST_HDR, ST_PAYLOAD}))) begin
            r_skip <= 1'b1;
         end else if (r_skip && !I_icmp_valid) begin
            r_skip <= 1'b0;
            r_drop <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (I_icmp_valid && !r_skip) begin
                  r_type   <= I_icmp_data;
                  r_src_ip <= I_icmp_src_ip_addr;
                  r_hi     <= I_icmp_data;
                  r_odd    <= 1'b1;
                  r_acc    <= '0;
                  r_idx    <= 3'd1;
                  r_state  <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (I_icmp_valid) begin
                  case (r_idx)
                     3'd1:    r_code         <= I_icmp_data;
                     3'd2:    r_cksum[15:8]  <= I_icmp_data;
                     3'd3:    r_cksum[7:0]   <= I_icmp_data;
                     3'd4:    r_id[15:8]     <= I_icmp_data;
                     3'd5:    r_id[7:0]      <= I_icmp_data;
                     3'd6:    r_seq[15:8]    <= I_icmp_data;
                     default: r_seq[7:0]     <= I_icmp_data;
                  endcase
                  r_acc <= w_acc_next;
                  r_odd <= !r_odd;
                  if (!r_odd) begin
                     r_hi <= I_icmp_data;
                  end
                  r_idx <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
                     r_pay_cnt <= '0;
                     r_too_big <= 1'b0;
                     r_state   <= ST_PAYLOAD;
                  end
               end else begin
                  r_drop  <= 1'b1;
                  r_state <= ST_DROP;
               end
            end
            ST_PAYLOAD: begin
               if (I_icmp_valid) begin
                  r_acc <= w_acc_next;
                  r_odd <= !r_odd;
                  if (!r_odd) begin
                     r_hi <= I_icmp_data;
                  end
                  if (r_pay_cnt == c_DEPTH) begin
                     r_too_big <= 1'b1;
                  end else begin
                     r_pay_cnt <= r_pay_cnt + 10'd1;
                  end
               end else begin
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_good) begin
                  r_req_en  <= 1'b1;
                  r_o_id    <= r_id;
                  r_o_seq   <= r_seq;
                  r_o_cksum <= reply_cksum(r_cksum);
                  r_o_ip    <= r_src_ip;
                  r_o_len   <= r_pay_cnt;
                  r_state   <= ST_REQ;
               end else begin
                  r_drop  <= 1'b1;
                  r_state <= ST_DROP;
               end
            end
            ST_DROP: begin
               r_state <= ST_IDLE;
            end
            ST_REQ: begin
               r_drain_cnt <= '0;
               r_state     <= (r_o_len == 10'd0) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_pop) begin
                  r_drain_cnt <= r_drain_cnt + 10'd1;
               end
               if (r_drain_cnt == r_o_len) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uiicmp_echo_fifo #(
      .DEPTH (ECHO_DEPTH)
   ) u_fifo (
      .I_clk     (I_clk),
      .I_reset   (I_reset),
      .I_wr_en   (w_wr_en),
      .I_wr_data (I_icmp_data),
      .I_commit  (r_state == ST_REQ),
      .I_rewind  (r_state == ST_DROP),
      .I_rd_en   (I_icmp_ping_echo_ren),
      .O_rd_data (O_icmp_ping_echo_data),
      .O_empty   (w_empty)
   );

   assign O_icmp_req_en             = r_req_en;
   assign O_icmp_rx_drop            = r_drop;
   assign O_icmp_req_id             = r_o_id;
   assign O_icmp_req_sq_num         = r_o_seq;
   assign O_icmp_req_checksum       = r_o_cksum;
   assign O_icmp_req_ip_addr        = r_o_ip;
   assign O_icmp_ping_echo_data_len = r_o_len;

endmodule

`default_nettype wire

// File: tb/tb_uiicmp_pkg_rx.sv
// ==========================================================================
// tb_uiicmp_pkg_rx : directed self-checking bench for uiicmp_pkg_rx
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_uiicmp_pkg_rx;
   import uiicmp_pkg_rx_pkg::*;

   logic        I_clk = 1'b0;
   logic        I_reset = 1'b1;
   logic        I_icmp_valid = 1'b0;
   logic [7:0]  I_icmp_data = 8'h00;
   logic [31:0] I_icmp_src_ip_addr = 32'h0;
   logic        I_icmp_ping_echo_ren = 1'b0;
   logic        O_icmp_req_en;
   logic [15:0] O_icmp_req_id;
   logic [15:0] O_icmp_req_sq_num;
   logic [15:0] O_icmp_req_checksum;
   logic [31:0] O_icmp_req_ip_addr;
   logic [9:0]  O_icmp_ping_echo_data_len;
   logic [7:0]  O_icmp_ping_echo_data;
   logic        O_icmp_rx_drop;

   int n_checks = 0;
   int n_errors = 0;
   int n_req    = 0;
   int n_drop   = 0;
   int req0;
   int drop0;

   logic [7:0] pkt[$];
   logic [7:0] pay[$];
   logic [7:0] exp_q[$];

   uiicmp_pkg_rx #(.ECHO_DEPTH(512)) dut (
      .I_clk                     (I_clk),
      .I_reset                   (I_reset),
      .I_icmp_valid              (I_icmp_valid),
      .I_icmp_data               (I_icmp_data),
      .I_icmp_src_ip_addr        (I_icmp_src_ip_addr),
      .O_icmp_req_en             (O_icmp_req_en),
      .O_icmp_req_id             (O_icmp_req_id),
      .O_icmp_req_sq_num         (O_icmp_req_sq_num),
      .O_icmp_req_checksum       (O_icmp_req_checksum),
      .O_icmp_req_ip_addr        (O_icmp_req_ip_addr),
      .O_icmp_ping_echo_data_len (O_icmp_ping_echo_data_len),
      .O_icmp_ping_echo_data     (O_icmp_ping_echo_data),
      .I_icmp_ping_echo_ren      (I_icmp_ping_echo_ren),
      .O_icmp_rx_drop            (O_icmp_rx_drop)
   );

   always #5 I_clk = ~I_clk;

   always @(negedge I_clk) begin
      if (O_icmp_req_en === 1'b1) n_req++;
      if (O_icmp_rx_drop === 1'b1) n_drop++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] model_cksum();
      logic [31:0] s = 32'h0;
      for (int i = 0; i < pkt.size(); i++)
         s += (i % 2 == 0) ? (32'(pkt[i]) << 8) : 32'(pkt[i]);
      while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return ~s[15:0];
   endfunction

   function automatic logic [15:0] model_reply(input logic [15:0] c);
      logic [31:0] t = 32'(c) + 32'h0800;
      return t[15:0] + {15'h0, t[16]};
   endfunction

   task automatic make_pkt(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] id,
                           input logic [15:0] seq, input int plen, input logic [7:0] seed);
      logic [15:0] ck;
      pay.delete();
      for (int i = 0; i < plen; i++) pay.push_back(8'(i * 7) ^ seed);
      pkt = '{typ, code, 8'h00, 8'h00, id[15:8], id[7:0], seq[15:8], seq[7:0]};
      foreach (pay[i]) pkt.push_back(pay[i]);
      ck = model_cksum();
      pkt[2] = ck[15:8];
      pkt[3] = ck[7:0];
   endtask

   task automatic make_ping1();
      string s = "abcdefghijklmnopqrstuvwabcdefghi";
      pay.delete();
      for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
      pkt = '{8'h08, 8'h00, 8'h4D, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h01};
      foreach (pay[i]) pkt.push_back(pay[i]);
   endtask

   task automatic send(input logic [31:0] ip);
      req0  = n_req;
      drop0 = n_drop;
      I_icmp_src_ip_addr = ip;
      foreach (pkt[i]) begin
         @(posedge I_clk); #1;
         I_icmp_valid = 1'b1;
         I_icmp_data  = pkt[i];
      end
      @(posedge I_clk); #1;
      I_icmp_valid = 1'b0;
      I_icmp_data  = 8'h00;
      repeat (6) @(posedge I_clk);
      #1;
   endtask

   task automatic expect_counts(input string tag, input int dreq, input int ddrop);
      check({tag, "_req"},  32'(n_req - req0),   32'(dreq));
      check({tag, "_drop"}, 32'(n_drop - drop0), 32'(ddrop));
   endtask

   task automatic drain(input string tag, input int n);
      int         bad = 0;
      logic [7:0] first = 8'h00;
      for (int i = 0; i < n; i++) begin
         I_icmp_ping_echo_ren = 1'b1;
         @(negedge I_clk);
         if (O_icmp_ping_echo_data !== exp_q[i]) bad++;
         if (i == 0) first = O_icmp_ping_echo_data;
         @(posedge I_clk); #1;
      end
      I_icmp_ping_echo_ren = 1'b0;
      check({tag, "_first"}, 32'(first), 32'(exp_q[0]));
      check({tag, "_bytes_bad"}, 32'(bad), 32'd0);
      repeat (2) @(posedge I_clk);
      #1;
      check({tag, "_state_idle"}, 32'(dut.r_state), 32'(ST_IDLE));
      check({tag, "_empty"}, 32'(dut.u_fifo.O_empty), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_en"}, 32'(O_icmp_req_en), 32'd0);
      check({tag, "_drop"},   32'(O_icmp_rx_drop), 32'd0);
      check({tag, "_id"},     32'(O_icmp_req_id), 32'd0);
      check({tag, "_seq"},    32'(O_icmp_req_sq_num), 32'd0);
      check({tag, "_cksum"},  32'(O_icmp_req_checksum), 32'd0);
      check({tag, "_ip"},     O_icmp_req_ip_addr, 32'd0);
      check({tag, "_len"},    32'(O_icmp_ping_echo_data_len), 32'd0);
      check({tag, "_data"},   32'(O_icmp_ping_echo_data), 32'd0);
      check({tag, "_empty"},  32'(dut.u_fifo.O_empty), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge I_clk);
      #1;
      check_zero("rst");
      I_reset = 1'b0;
      repeat (2) @(posedge I_clk);
      #1;

      // 1: reference Windows-style ping
      make_ping1();
      exp_q = pay;
      send(32'hC0A80164);
      expect_counts("t1", 1, 0);
      check("t1_id",    32'(O_icmp_req_id), 32'h0001);
      check("t1_seq",   32'(O_icmp_req_sq_num), 32'h0001);
      check("t1_cksum", 32'(O_icmp_req_checksum), 32'h555A);
      check("t1_len",   32'(O_icmp_ping_echo_data_len), 32'd32);
      check("t1_ip",    O_icmp_req_ip_addr, 32'hC0A80164);
      drain("t1", 32);

      // 2: corrupted payload byte, then the clean packet again
      make_ping1();
      pkt[13] = pkt[13] ^ 8'h01;
      send(32'hC0A80164);
      expect_counts("t2", 0, 1);
      check("t2_empty", 32'(dut.u_fifo.O_empty), 32'd1);
      make_ping1();
      exp_q = pay;
      send(32'hC0A80165);
      expect_counts("t2b", 1, 0);
      check("t2b_ip", O_icmp_req_ip_addr, 32'hC0A80165);
      drain("t2b", 32);

      // 3: echo reply type, then a truncated header
      make_pkt(ICMP_TYPE_ECHO_REPLY, 8'h00, 16'h1234, 16'h0007, 10, 8'h33);
      send(32'h0A000001);
      expect_counts("t3a", 0, 1);
      pkt = '{8'h08, 8'h00, 8'h12, 8'h34, 8'h56};
      send(32'h0A000002);
      expect_counts("t3b", 0, 1);

      // 4: second request while the first is still buffered
      make_pkt(8'h08, 8'h00, 16'hAB01, 16'h0100, 20, 8'h11);
      exp_q = pay;
      send(32'h0A000003);
      expect_counts("t4a", 1, 0);
      make_pkt(8'h08, 8'h00, 16'hAB02, 16'h0200, 15, 8'h22);
      send(32'h0A000004);
      expect_counts("t4b", 0, 1);
      check("t4b_id_hold", 32'(O_icmp_req_id), 32'hAB01);
      drain("t4a", 20);
      make_pkt(8'h08, 8'h00, 16'hAB03, 16'h0300, 7, 8'h44);
      exp_q = pay;
      send(32'h0A000005);
      expect_counts("t4c", 1, 0);
      check("t4c_id",    32'(O_icmp_req_id), 32'hAB03);
      check("t4c_cksum", 32'(O_icmp_req_checksum), 32'(model_reply({pkt[2], pkt[3]})));
      check("t4c_len",   32'(O_icmp_ping_echo_data_len), 32'd7);
      drain("t4c", 7);

      // 5: one byte over capacity, then exactly full (pointers not at zero, so they wrap)
      make_pkt(8'h08, 8'h00, 16'h0513, 16'h0001, 513, 8'h5A);
      send(32'h0A000006);
      expect_counts("t5a", 0, 1);
      check("t5a_empty", 32'(dut.u_fifo.O_empty), 32'd1);
      make_pkt(8'h08, 8'h00, 16'h0512, 16'h0002, 512, 8'hA5);
      exp_q = pay;
      send(32'h0A000007);
      expect_counts("t5b", 1, 0);
      check("t5b_len",   32'(O_icmp_ping_echo_data_len), 32'd512);
      check("t5b_cksum", 32'(O_icmp_req_checksum), 32'(model_reply({pkt[2], pkt[3]})));
      drain("t5b", 512);

      // 6: reset in the middle of a payload
      make_pkt(8'h08, 8'h00, 16'h0600, 16'h0001, 40, 8'h66);
      for (int i = 0; i < 20; i++) begin
         @(posedge I_clk); #1;
         I_icmp_valid = 1'b1;
         I_icmp_data  = pkt[i];
      end
      I_reset = 1'b1;
      #1;
      check_zero("t6_rst");
      I_icmp_valid = 1'b0;
      @(posedge I_clk); #1;
      I_reset = 1'b0;
      repeat (2) @(posedge I_clk);
      #1;
      make_pkt(8'h08, 8'h00, 16'hFFFE, 16'h0000, 0, 8'h00);
      check("t6_req_cksum_in", 32'({pkt[2], pkt[3]}), 32'h0000F800);
      send(32'h0A000008);
      expect_counts("t6", 1, 0);
      check("t6_cksum", 32'(O_icmp_req_checksum), 32'h0001);
      check("t6_len",   32'(O_icmp_ping_echo_data_len), 32'd0);
      check("t6_state", 32'(dut.r_state), 32'(ST_IDLE));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
